contador_mod_ud: RTL
====================

Name: contador_mod_ud

Overview:
- Parametrised, programmable-modulus up/down counter. Next generation of the team's fixed 4-bit enable/up-down counter.
- Adds: configurable width, runtime limit, parallel load, wrap/saturate mode, terminal-count pulse, saturation flag.
- Used as a general timing/event counter in the basic-course datapaths. Can be cascaded via tc.

Parameters:
- WIDTH, 4, counter width in bits (≥2).
- PRESC_DIV, 4, prescaler division ratio when PRESCALER_EN is defined (≥2; ignored otherwise).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- enable  input  1  count enable.
- UD  input  1  direction: 1 = up, 0 = down.
- load  input  1  synchronous parallel load.
- dato  input  WIDTH  load value.
- limite  input  WIDTH  maximum count, inclusive; sequence is 0..limite.
- modo  input  1  0 = wrap, 1 = saturate.
- cuenta  output  WIDTH  registered count.
- tc  output  1  registered terminal-count pulse.
- saturado  output  1  registered saturation flag.

Interface rule: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst=0, asynchronous): cuenta=0, tc=0, saturado=0, prescaler=0. Outputs hold until the first rising clk after rst=1.
- Priority per rising clk: load > enable > hold.
- Load: cuenta <= min(dato, limite). tc=0. saturado=0. Load acts regardless of enable and does not advance the prescaler.
- Enabled step, up (UD=1):
  - cuenta<limite: increment.
  - cuenta==limite, wrap mode: cuenta<=0, tc=1.
  - cuenta==limite, saturate mode: hold, saturado=1.
- Enabled step, down (UD=0):
  - cuenta>0: decrement.
  - cuenta==0, wrap mode: cuenta<=limite, tc=1.
  - cuenta==0, saturate mode: hold, saturado=1.
- Out-of-range (cuenta>limite after limite is lowered), on the next enabled step:
  - up: wrap mode gives 0 with tc=1; saturate mode gives limite with saturado=1.
  - down: cuenta<=limite, no tc.
- limite=0: cuenta stays 0. In wrap mode, tc=1 on every enabled step. In saturate mode, saturado=1.
- tc timing: high for exactly one cycle, coincident with the cycle cuenta shows the wrapped value. Low in every other cycle, including hold and load cycles.
- saturado: set only by a blocked step. Cleared by any successful step, load, or a direction change that moves away from the bound. Holds its value while enable=0.
- Direction or mode changes take effect on the same edge; no pipeline.
- Latency: one cycle from input to cuenta/tc/saturado.
- No arithmetic overflow: all comparisons are unsigned WIDTH-bit; ±1 computed only when in range.

Optional Feature:
- Macro: CONTADOR_PRESCALER_EN.
- Defined:
  - A prescaler counts 0..PRESC_DIV-1 while enable=1. An enabled step occurs only in the cycle the prescaler equals PRESC_DIV-1.
  - The prescaler wraps to 0 after that cycle and holds while enable=0.
  - load has priority and resets the prescaler to 0.
- Not defined: every cycle with enable=1 is a step; no prescaler logic is synthesised.

Decomposition:
- Package contador_pkg:
  - typedef enum {MODO_WRAP=0, MODO_SAT=1} modo_t.
  - Constants UD_UP=1, UD_DOWN=0.
- Natural sub-module: contador_prescaler (tick generator). Instantiated only under CONTADOR_PRESCALER_EN.

Test Plan (WIDTH=4, macro undefined unless stated):
- Reset mid-count: count up to 5, drop rst asynchronously between edges -> cuenta=0, tc=0, saturado=0 immediately, before the next edge.
- Wrap up: limite=9, modo=0, UD=1, enable=1 from 0 -> sequence 0..9,0. tc=1 only in the cycle cuenta returns to 0. Down from 0 -> 9 with tc=1.
- Saturate: limite=9, modo=1, UD=1 -> cuenta holds 9, saturado=1. Switch UD=0 -> next cuenta=8, saturado=0.
- Load clamp and priority: load=1, dato=12, limite=9, enable=1 -> cuenta=9, tc=0. Load dato=3 -> cuenta=3.
- Limit lowered: cuenta=8, limite changed to 5, UD=1, modo=0 -> cuenta=0 with tc=1. Repeat with modo=1 -> cuenta=5, saturado=1.
- Prescaler (CONTADOR_PRESCALER_EN, PRESC_DIV=4): enable=1 for 12 cycles -> cuenta advances 0→3, one step every 4th cycle. Deassert enable mid-period -> prescaler holds; resumes on re-enable.

Source files
------------

// File: rtl/contador_pkg.sv
// Shared types and constants for the programmable-modulus up/down counter.
package contador_pkg;

  typedef enum logic {
    MODO_WRAP = 1'b0,
    MODO_SAT  = 1'b1
  } modo_t;

  localparam logic UD_UP   = 1'b1;
  localparam logic UD_DOWN = 1'b0;

endpackage

// File: rtl/contador_prescaler.sv
// Tick generator: counts 0..DIV-1 while enabled and flags the last count of each period.
module contador_prescaler #(
  parameter int unsigned DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] Last = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A clear (parallel load) always wins, so no tick may escape in that cycle.
  assign tick_o = en_i && !clr_i && (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == Last) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/contador_mod_ud.sv
// Programmable-modulus up/down counter with load, wrap/saturate, tc pulse and saturation flag.
// Define CONTADOR_PRESCALER_EN to make steps happen only once every PRESC_DIV enabled cycles.
module contador_mod_ud
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned PRESC_DIV = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             ud_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] dato_i,
  input  logic [WIDTH-1:0] limite_i,
  input  logic             modo_i,
  output logic [WIDTH-1:0] cuenta_o,
  output logic             tc_o,
  output logic             saturado_o
);

  if (WIDTH < 2 || PRESC_DIV < 2) begin : g_bad_param
    $error("contador_mod_ud: WIDTH and PRESC_DIV must both be at least 2");
  end

  logic [WIDTH-1:0] cuenta_q, cuenta_d;
  logic             tc_q, tc_d;
  logic             sat_q, sat_d;
  logic             step;
  modo_t            modo;

  assign modo = modo_t'(modo_i);

`ifdef CONTADOR_PRESCALER_EN
  contador_prescaler #(
    .DIV (PRESC_DIV)
  ) u_presc (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (enable_i),
    .clr_i  (load_i),
    .tick_o (step)
  );
`else
  assign step = enable_i;
`endif

  always_comb begin
    cuenta_d = cuenta_q;
    tc_d     = 1'b0;
    sat_d    = sat_q;
    if (load_i) begin
      cuenta_d = (dato_i > limite_i) ? limite_i : dato_i;
      sat_d    = 1'b0;
    end else if (step) begin
      sat_d = 1'b0;
      if (ud_i == UD_UP) begin
        if (cuenta_q < limite_i) begin
          cuenta_d = cuenta_q + WIDTH'(1);
        end else if (modo == MODO_WRAP) begin
          cuenta_d = '0;
          tc_d     = 1'b1;
        end else begin
          // Also pulls an out-of-range count back onto the limit.
          cuenta_d = limite_i;
          sat_d    = 1'b1;
        end
      end else begin
        if (cuenta_q > limite_i) begin
          cuenta_d = limite_i;
        end else if (cuenta_q != '0) begin
          cuenta_d = cuenta_q - WIDTH'(1);
        end else if (modo == MODO_WRAP) begin
          cuenta_d = limite_i;
          tc_d     = 1'b1;
        end else begin
          sat_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cuenta_q <= '0;
      tc_q     <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      cuenta_q <= cuenta_d;
      tc_q     <= tc_d;
      sat_q    <= sat_d;
    end
  end

  assign cuenta_o   = cuenta_q;
  assign tc_o       = tc_q;
  assign saturado_o = sat_q;

endmodule
